// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed 7-segment driver: shadows a BCD word and scans it onto registered seg/an outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (thousands..tens); units always shown.
module bcd_display_mux #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] bcd_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_err;

    logic          w_tick;
    logic [PW-1:0] w_presc_nxt;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_shadow_nxt;
    logic [3:0]    w_digit;
    logic [3:0]    w_lz;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;
    logic          w_bad;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign w_tick       = (r_presc == PRESC_MAX);
    assign w_presc_nxt  = w_tick ? '0 : r_presc + 1'b1;
    assign w_idx_nxt    = w_tick ? r_idx + 2'd1 : r_idx;
    assign w_shadow_nxt = load ? bcd_in : r_shadow;

    // Outputs are computed from next-state values so an and seg move together on the same edge.
    assign w_digit = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];

    // w_lz[i]: digit i and every higher digit are zero.
    assign w_lz[3] = (w_shadow_nxt[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] & (w_shadow_nxt[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] & (w_shadow_nxt[7:4] == 4'd0);
    assign w_lz[0] = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = w_lz[w_idx_nxt];
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg_nxt = w_blank ? 7'b0000000 : f_decode(w_digit);
    assign w_an_nxt  = 4'b0001 << w_idx_nxt;

    // Sampling the shadow makes err rise one edge after the offending capture.
    assign w_bad = (r_shadow[3:0]   > 4'd9) | (r_shadow[7:4]   > 4'd9) |
                   (r_shadow[11:8]  > 4'd9) | (r_shadow[15:12] > 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc  <= '0;
            r_idx    <= 2'd0;
            r_shadow <= 16'h0000;
            r_an     <= 4'b0001;
            r_seg    <= 7'b0111111;
            r_err    <= 1'b0;
        end else begin
            r_presc  <= w_presc_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
            r_an     <= w_an_nxt;
            r_seg    <= w_seg_nxt;
            r_err    <= r_err | w_bad;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign err = r_err;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized bench for bcd_display_mux (SCAN_DIV=4) against a cycle-count based display model.
module tb_bcd_display_mux;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;

    bcd_display_mux #(.SCAN_DIV(DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bcd_in (bcd_in),
        .seg    (seg),
        .an     (an),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: edges since last reset, shadow copy, sticky error.
    int          m_cnt    = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic        m_err    = 1'b0;

    logic [6:0] seg_tbl [16];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic has_bad(input logic [15:0] w);
        for (int i = 0; i < 4; i++)
            if (((w >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int digit_of(input logic [15:0] w, input int i);
        return int'((w >> (4 * i)) & 16'hF);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] w, input int slot);
        int d;
        d = digit_of(w, slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (w >> (4 * slot)) == 16'h0) return 7'b0000000;
`endif
        return seg_tbl[d];
    endfunction

    // One clock with the given inputs, then model update and compare.
    task automatic step(input logic r, input logic l, input logic [15:0] b);
        int slot;
        reset  = r;
        load   = l;
        bcd_in = b;
        @(posedge clk);
        if (r) begin
            m_cnt    = 0;
            m_shadow = 16'h0000;
            m_err    = 1'b0;
        end else begin
            m_err    = m_err | has_bad(m_shadow);
            if (l) m_shadow = b;
            m_cnt++;
        end
        #1;
        slot = (m_cnt / DIV) % 4;
        chk("an",  {12'h0, an},  16'(4'b0001 << slot));
        chk("seg", {9'h0, seg},  {9'h0, exp_seg(m_shadow, slot)});
        chk("err", {15'h0, err}, {15'h0, m_err});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        seg_tbl[0]  = 7'b0111111; seg_tbl[1]  = 7'b0000110;
        seg_tbl[2]  = 7'b1011011; seg_tbl[3]  = 7'b1001111;
        seg_tbl[4]  = 7'b1100110; seg_tbl[5]  = 7'b1101101;
        seg_tbl[6]  = 7'b1111101; seg_tbl[7]  = 7'b0000111;
        seg_tbl[8]  = 7'b1111111; seg_tbl[9]  = 7'b1101111;
        for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b0000000;

        @(negedge clk);
        step(1'b1, 1'b1, 16'h9999);     // reset overrides load
        chk("rst_an",  {12'h0, an},  16'h0001);
        chk("rst_seg", {9'h0, seg},  16'h003F);
        idle(16);

        step(1'b0, 1'b1, 16'h1259);
        idle(17);

        step(1'b0, 1'b1, 16'h00A3);
        idle(3);
        step(1'b0, 1'b1, 16'h0000);
        idle(10);
        chk("err_sticky", {15'h0, err}, 16'h0001);
        step(1'b1, 1'b0, 16'h0);
        chk("err_clr", {15'h0, err}, 16'h0000);

        // Load on the tick cycle (3 idles after reset put prescaler at 3), then reset mid-slot.
        idle(3);
        step(1'b0, 1'b1, 16'h4321);
        chk("tick_load_an",  {12'h0, an},  16'h0002);
        chk("tick_load_seg", {9'h0, seg},  16'h005B);
        idle(6);
        step(1'b1, 1'b0, 16'h0);
        idle(8);

        step(1'b0, 1'b1, 16'h0007);
        idle(16);
        step(1'b0, 1'b1, 16'h0100);
        idle(16);

        for (int i = 0; i < 3000; i++) begin
            logic        r, l;
            logic [15:0] b;
            r = ($urandom_range(0, 79) == 0);
            l = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0)
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = b & 16'h00FF;
            step(r, l, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit scan slot (legal range >= 1).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  capture strobe for bcd_in.
REQ-005 bcd_in  input  16  four BCD digits from the cascaded counter chain; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-006 seg  output  7  registered segment drive, active-high, {g,f,e,d,c,b,a}.
REQ-007 an  output  4  registered one-hot digit enable, active-high; an[0] = units.
REQ-008 err  output  1  sticky flag: a non-BCD digit was loaded.

Function
REQ-009 Shadow register SHALL capture bcd_in on any edge with load=1; it holds otherwise.
REQ-010 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; the wrap cycle is the scan tick.
REQ-011 Scan index SHALL advance 0->1->2->3->0 on each tick only.
REQ-012 SCAN_DIV=1 SHALL give a tick every cycle.
REQ-013 an SHALL be one-hot of the scan index, registered; it changes on the edge the index changes.
REQ-014 seg SHALL be the registered decode of the shadow digit at the current index; an and seg SHALL always refer to the same digit (no mismatched-digit cycle).
REQ-015 Decode, digits 0-9: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-016 Digit values 10-15 SHALL decode to seg=0000000.
REQ-017 err SHALL set on the edge after a load captures any digit >9; it clears only on reset.
REQ-018 load and tick in the same cycle: the shadow update and the index advance SHALL both occur; the next output pair SHALL show the new shadow at the new index.
REQ-019 The first display of loaded data SHALL be at most 1 cycle after capture when the index does not change.

Reset
REQ-020 reset=1 SHALL force prescaler=0, index=0, shadow=0x0000, an=0001, seg=0111111, err=0 on the same edge; reset overrides load.
REQ-021 Reset asserted mid-scan SHALL abort the slot; the scan restarts at the units digit with a full SCAN_DIV period.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN defined: digits 3..1 SHALL show seg=0000000 when that digit and all higher digits are 0; digit 0 is never blanked; an keeps cycling.
REQ-023 Macro LEADING_ZERO_BLANK_EN undefined: all four digits SHALL decode normally, including leading zeros.

Verification (SCAN_DIV=4)
REQ-024 Reset, then idle for 16 cycles -> an cycles 0001,0010,0100,1000 with 4 cycles each; seg=0111111 throughout (macro off).
REQ-025 load=1 with bcd_in=0x1259 -> per slot, seg shows 9=1101111, 5=1101101, 2=1011011, 1=0000110 with an 0001..1000; err=0.
REQ-026 load with bcd_in=0x00A3 -> the tens slot shows seg=0000000; err=1 on the next edge; err stays 1 after load 0x0000; reset clears it.
REQ-027 Macro on, load 0x0007 -> only the units slot shows 0000111; the other slots show 0000000. Load 0x0100 -> the hundreds, tens and units slots light.
REQ-028 Assert load and the tick in the same cycle, then reset at prescaler=2 in slot 2 -> the REQ-018 output follows; the next edge gives an=0001, seg=0111111, and the first tick is 4 cycles later.
